// File: rtl/prm_edge_mask_accum.sv
// Collects checker-bank edge masks over a frame of voxel codes and hands the blocked-edge mask downstream.
// Optional popcount output hit_cnt is enabled by defining PRM_HIT_CNT_EN.
module prm_edge_mask_accum #(
    parameter int unsigned NUM_EDGES = 16,
    parameter int unsigned PT_W      = 15,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               pt_valid,
    output logic                               pt_ready,
    input  logic [PT_W-1:0]                    pt_code,
    input  logic                               pt_last,
    output logic [PT_W-1:0]                    chk_code,
    input  logic [NUM_EDGES-1:0]               chk_mask,
    output logic                               mask_valid,
    input  logic                               mask_ready,
    output logic [NUM_EDGES-1:0]               mask_out,
`ifdef PRM_HIT_CNT_EN
    output logic [CNT_W-1:0]                   pt_count,
    output logic [$clog2(NUM_EDGES+1)-1:0]     hit_cnt
`else
    output logic [CNT_W-1:0]                   pt_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   pt_ready_nxt;
    logic                   mask_valid_nxt;
    logic                   accept;
    logic                   s1_vld;
    logic [NUM_EDGES-1:0]   acc;
    logic [NUM_EDGES-1:0]   acc_merged;

    assign accept     = pt_valid & pt_ready;
    // Accumulator including the mask of the code currently on the checker bank.
    assign acc_merged = s1_vld ? (acc | chk_mask) : acc;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of the registered handshake outputs.
    always_comb begin
        state_nxt      = state;
        pt_ready_nxt   = 1'b0;
        mask_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = pt_last ? FLUSH : ACC;
                end
            end
            ACC: begin
                if (accept && pt_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (mask_valid && mask_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        pt_ready_nxt   = (state_nxt == IDLE) || (state_nxt == ACC);
        mask_valid_nxt = (state_nxt == OUT);
    end

    // Point pipeline, accumulator and counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pt_ready   <= 1'b1;
            mask_valid <= 1'b0;
            chk_code   <= '0;
            s1_vld     <= 1'b0;
            acc        <= '0;
            pt_count   <= '0;
        end else begin
            pt_ready   <= pt_ready_nxt;
            mask_valid <= mask_valid_nxt;
            s1_vld     <= accept;
            if (accept) begin
                chk_code <= pt_code;
            end
            // First accept of a frame discards the previous frame's accumulation.
            if (accept && (state == IDLE)) begin
                acc      <= '0;
                pt_count <= CNT_W'(1);
            end else begin
                acc <= acc_merged;
                if (accept && (pt_count != CNT_MAX)) begin
                    pt_count <= pt_count + CNT_W'(1);
                end
            end
        end
    end

    // Result capture at the end of FLUSH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mask_out <= '0;
        end else if (state == FLUSH) begin
            mask_out <= acc_merged;
        end
    end

`ifdef PRM_HIT_CNT_EN
    localparam int unsigned HIT_W = $clog2(NUM_EDGES + 1);

    logic [HIT_W-1:0] hit_cnt_nxt;

    // Population count of the final frame mask.
    always_comb begin
        hit_cnt_nxt = '0;
        for (int unsigned i = 0; i < NUM_EDGES; i++) begin
            hit_cnt_nxt = hit_cnt_nxt + HIT_W'(acc_merged[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt <= '0;
        end else if (state == FLUSH) begin
            hit_cnt <= hit_cnt_nxt;
        end
    end
`endif

endmodule
